mmio_bridge: RTL
================

Name: mmio_bridge

Overview:
- Downstream data-side stage of the single-cycle CPU. Consumes the CPU's data address, store data and write strobe, and returns load data on the CPU's data input.
- Decodes each access to either data RAM or a memory-mapped I/O window. The window holds an LED register, synchronized switches, a FIFO-buffered 8N1 UART transmitter and a free-running cycle counter.
- Loads are combinational, because the CPU has no stall. Stores and all I/O state update on the rising clock edge.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 4, UART TX FIFO entries; power of two, 2..16

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- addr_in  in  32  CPU data address
- wdata_in  in  32  CPU store data
- we_in  in  1  CPU store strobe; 1 = write
- rdata_out  out  32  load data to CPU; combinational
- ram_we  out  1  data RAM write enable; combinational
- ram_rdata  in  32  data RAM read data, same-cycle
- sw_in  in  16  board switches, asynchronous
- led_out  out  16  LED register
- uart_tx  out  1  serial output; idle high

Behaviour:
- Reset is asynchronous on rst=0 and released synchronously in effect at the first edge after rst=1. Reset values:
  - led_out = 0, uart_tx = 1
  - FIFO empty, drop count = 0, cycle counter = 0
  - switch synchronizer flops = 0, UART FSM = IDLE
- Decode: MMIO when addr_in[31:28] == 4'hF; otherwise RAM.
  - ram_we = we_in & ~mmio.
  - RAM access: rdata_out = ram_rdata.
- MMIO register select is addr_in[4:2]; addr_in[1:0] and addr_in[27:5] are ignored.
  - 0 LED: reads {16'h0, led}. A write loads wdata_in[15:0] at the edge.
  - 1 SW: reads {16'h0, sw_sync}. sw_sync is sw_in through two flops, so 2-cycle latency. Writes ignored.
  - 2 UART_DATA: a write pushes wdata_in[7:0]. If the FIFO is full (after any same-cycle pop), the byte is dropped and the drop count increments, saturating at 255. Reads 0.
  - 3 UART_STAT: reads {16'h0, drop_cnt[7:0], 5'h0, fifo_empty, fifo_full, tx_busy}. Writes ignored.
  - 4 CYCLE: reads the counter. Any write clears it to 0 at that edge; the write wins over the increment.
  - 5..7: read 0, writes ignored.
- Cycle counter: 32-bit, increments every cycle, wraps 32'hFFFFFFFF -> 0.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START on the next cycle.
  - START: uart_tx = 0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: uart_tx = 1 for CLK_DIV cycles, then IDLE.
  - Frame time is 10*CLK_DIV cycles. A back-to-back byte adds 1 IDLE cycle between frames.
- tx_busy = (state != IDLE).
- A bit counter of 3 bits and a divider counter of 16 bits; the divider reloads on every bit boundary.
- Simultaneous push and pop on a full FIFO: the pop frees a slot and the push is accepted (not dropped). The drop count does not change.
- FIFO pointers wrap modulo FIFO_DEPTH. full/empty are derived from an extra pointer wrap bit.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously). The frame is abandoned and the FIFO contents are discarded.

Optional Feature:
- Macro: MMIO_CYCLE_COUNTER_EN.
- Defined: the cycle counter exists as described and is readable and clearable at select 4.
- Undefined: no counter flops are instantiated. Select 4 reads 0 and writes to it are ignored.

Test Plan:
- Reset then store 0x0000A5A5 to 0xF0000000 -> led_out = 16'hA5A5 after the edge; a load from 0xF0000000 returns 0x0000A5A5; ram_we = 0 throughout.
- Store to 0x00000010 with we_in = 1 -> ram_we = 1. A load with ram_rdata = 0x12345678 -> rdata_out = 0x12345678 in the same cycle.
- sw_in = 16'h00F0 -> a load from 0xF0000004 returns 0x000000F0 on the third cycle after the change, and the old value before that.
- CLK_DIV = 4, push 0x55 to 0xF0000008 -> uart_tx shows 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop), each for 4 cycles. STAT bit0 = 1 during the frame and 0 afterwards.
- CLK_DIV = 4, FIFO_DEPTH = 4, six back-to-back pushes -> the first byte is popped the cycle after its push, 4 are buffered, 1 is dropped. STAT[15:8] = 1, and 5 frames are transmitted in order.
- With MMIO_CYCLE_COUNTER_EN defined, write to 0xF0000010, then read 3 cycles later -> returns 3. Assert rst = 0 mid-frame -> uart_tx = 1 immediately, STAT = 0x00000004.

Source files
------------

// File: rtl/mmio_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mmio_bridge
//   Data-side stage of the single-cycle CPU. Decodes each data access to either
//   the data RAM or a memory-mapped I/O window at addr_in[31:28] == 4'hF.
//   Loads are combinational (the CPU never stalls); stores and all I/O state
//   update on the rising clock edge.
//
//   MMIO map (select = addr_in[4:2]):
//     0 LED        r/w  {16'h0, led}
//     1 SW         r    {16'h0, sw_sync} (two-flop synchronized switches)
//     2 UART_DATA  w    push a byte into the TX FIFO (reads 0)
//     3 UART_STAT  r    {16'h0, drop_cnt, 5'h0, fifo_empty, fifo_full, tx_busy}
//     4 CYCLE      r/w  free-running cycle counter, any write clears it
//     5..7         reads 0, writes ignored
//
//   Optional feature macro: MMIO_CYCLE_COUNTER_EN
//     defined   -> cycle counter present at select 4
//     undefined -> no counter flops; select 4 reads 0, writes ignored
//
//   Parameters:
//     CLK_DIV     clock cycles per UART bit (2..65535)
//     FIFO_DEPTH  UART TX FIFO entries (power of two, 2..16)
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   asynchronous active-low reset
//     addr_in    in   [31:0] CPU data address
//     wdata_in   in   [31:0] CPU store data
//     we_in      in   CPU store strobe
//     rdata_out  out  [31:0] load data to CPU (combinational)
//     ram_we     out  data RAM write enable (combinational)
//     ram_rdata  in   [31:0] data RAM read data, same cycle
//     sw_in      in   [15:0] board switches, asynchronous
//     led_out    out  [15:0] LED register
//     uart_tx    out  8N1 serial output, idle high
// -----------------------------------------------------------------------------
module mmio_bridge #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        we_in,
    output logic [31:0] rdata_out,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        uart_tx
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_mmio;
    logic [2:0] w_sel;
    logic       w_wr_mmio;

    assign w_mmio    = (addr_in[31:28] == 4'hF);
    assign w_sel     = addr_in[4:2];
    assign w_wr_mmio = we_in & w_mmio;
    assign ram_we    = we_in & ~w_mmio;

    // Address/data bits the map deliberately ignores.
    logic w_unused_bits;
    assign w_unused_bits = ^{addr_in[27:5], addr_in[1:0], wdata_in[31:16]};

    // ------------------------------------------------------------------
    // LED register
    // ------------------------------------------------------------------
    logic [15:0] r_led;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led <= '0;
        end else if (w_wr_mmio && (w_sel == 3'd0)) begin
            r_led <= wdata_in[15:0];
        end
    end

    assign led_out = r_led;

    // ------------------------------------------------------------------
    // Switch synchronizer (two flops)
    // ------------------------------------------------------------------
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // UART TX FIFO
    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bits means full.
    // ------------------------------------------------------------------
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr_uart;
    logic        w_push;
    logic        w_drop;
    logic [7:0]  w_head;
    logic [7:0]  r_drop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_wr_uart = w_wr_mmio && (w_sel == 3'd2);
    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted when the transmitter is draining it.
    assign w_push    = w_wr_uart && (!w_full || w_pop);
    assign w_drop    = w_wr_uart && w_full && !w_pop;
    assign w_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata_in[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter (optional)
    // ------------------------------------------------------------------
    logic [31:0] w_cycle_rd;

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
        end else if (w_wr_mmio && (w_sel == 3'd4)) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_rd = r_cycle;
`else
    assign w_cycle_rd = '0;
`endif

    // ------------------------------------------------------------------
    // UART transmitter FSM
    // uart_tx is registered from the next-state decode so the pin never
    // glitches; its async reset drives it high immediately.
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_div;
    logic [15:0] w_div_nxt;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        r_tx;
    logic        w_tx_nxt;
    logic        w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_div_nxt   = DIV_RELOAD;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_div == 16'd0) begin
                    w_div_nxt   = DIV_RELOAD;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end
            S_DATA: begin
                if (r_div == 16'd0) begin
                    w_div_nxt   = DIV_RELOAD;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end
            S_STOP: begin
                if (r_div == 16'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == S_DATA) begin
            w_tx_nxt = w_shift_nxt[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign w_busy  = (r_state != S_IDLE);
    assign uart_tx = r_tx;

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata_out = ram_rdata;
        if (w_mmio) begin
            case (w_sel)
                3'd0:    rdata_out = {16'h0, r_led};
                3'd1:    rdata_out = {16'h0, r_sw_sync};
                3'd3:    rdata_out = {16'h0, r_drop, 5'h0, w_empty, w_full, w_busy};
                3'd4:    rdata_out = w_cycle_rd;
                default: rdata_out = 32'h0;
            endcase
        end
    end

endmodule
